// File: rtl/gan_pkg.sv
// Shared constants for the GAN batch scheduler: FSM encodings, default watchdog
// limit and the score sign-extension helper.
package gan_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LAUNCH   = 3'd1;
    localparam logic [2:0] ST_WAIT_RUN = 3'd2;
    localparam logic [2:0] ST_NEXT     = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd1000000;

    function automatic logic [31:0] sext_score(input logic [15:0] score);
        return {{16{score[15]}}, score};
    endfunction

endpackage

// File: rtl/gan_watchdog.sv
// Per-run watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the LIMIT-th enabled cycle is reached.
module gan_watchdog
    import gan_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (LIMIT > 32'd1) ? $clog2(LIMIT) : 32'd1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 32'd1);

    logic [CNT_W-1:0] cnt_r;

    // Cycle counter; holds at LAST so it never wraps while the FSM reacts.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign expired = enable && (cnt_r == LAST);

endmodule

// File: rtl/gan_batch_scheduler.sv
// Batch scheduler for the GAN core: launches a configured number of runs,
// waits for run completion (and optionally frame drain), accumulates statistics.
module gan_batch_scheduler
    import gan_pkg::*;
#(
    parameter int          COUNT_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter bit          WAIT_DRAIN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_start,
    input  logic                   cmd_abort,
    input  logic [COUNT_WIDTH-1:0] cfg_run_count,
    output logic                   gan_start,
    input  logic                   gan_done,
    input  logic                   disc_fake_is_real,
    input  logic [15:0]            disc_fake_score,
    input  logic                   frame_drained,
    output logic                   busy,
    output logic                   batch_done,
    output logic                   timeout_err,
    output logic [COUNT_WIDTH-1:0] runs_completed,
    output logic [COUNT_WIDTH-1:0] fooled_count,
    output logic [31:0]            fake_score_sum,
    output logic [2:0]             state_dbg
);

    logic [2:0]             state_r;
    logic [2:0]             state_nxt_s;
    logic [COUNT_WIDTH-1:0] count_cfg_r;
    logic [COUNT_WIDTH-1:0] runs_r;
    logic [COUNT_WIDTH-1:0] fooled_r;
    logic [31:0]            sum_r;
    logic                   done_flag_r;
    logic                   drain_flag_r;
    logic                   gan_start_r;
    logic                   busy_r;
    logic                   batch_done_r;
    logic                   timeout_err_r;

    logic in_wait_s;
    logic live_wait_s;
    logic done_seen_s;
    logic drain_seen_s;
    logic run_end_s;
    logic take_done_s;
    logic timeout_hit_s;
    logic accept_start_s;
    logic wd_clear_s;
    logic wd_expired_s;

    // Pulses arriving in the current cycle count together with the latched flags.
    assign in_wait_s      = (state_r == ST_WAIT_RUN);
    assign live_wait_s    = in_wait_s && !cmd_abort;
    assign done_seen_s    = done_flag_r || gan_done;
    assign drain_seen_s   = drain_flag_r || frame_drained || (WAIT_DRAIN == 1'b0);
    assign run_end_s      = done_seen_s && drain_seen_s;
    assign take_done_s    = live_wait_s && gan_done && !done_flag_r;
    assign timeout_hit_s  = live_wait_s && !run_end_s && wd_expired_s;
    assign accept_start_s = (state_r == ST_IDLE) && cmd_start;
    assign wd_clear_s     = !in_wait_s;

    gan_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear_s),
        .enable  (in_wait_s),
        .expired (wd_expired_s)
    );

    // Next-state decode; abort outranks every other event outside IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!cmd_start) begin
                    state_nxt_s = ST_IDLE;
                end else if (cfg_run_count == {COUNT_WIDTH{1'b0}}) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (cmd_abort) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_WAIT_RUN;
                end
            end
            ST_WAIT_RUN: begin
                if (cmd_abort) begin
                    state_nxt_s = ST_FINISH;
                end else if (run_end_s) begin
                    state_nxt_s = ST_NEXT;
                end else if (wd_expired_s) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_WAIT_RUN;
                end
            end
            ST_NEXT: begin
                if (cmd_abort) begin
                    state_nxt_s = ST_FINISH;
                end else if (runs_r == count_cfg_r) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_LAUNCH;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and the outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            gan_start_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            gan_start_r <= (state_nxt_s == ST_LAUNCH);
        end
    end

    // Completion and drain flags live only while a run is outstanding.
    always_ff @(posedge clk) begin
        if (rst || !in_wait_s) begin
            done_flag_r  <= 1'b0;
            drain_flag_r <= 1'b0;
        end else begin
            done_flag_r  <= done_flag_r || gan_done;
            drain_flag_r <= drain_flag_r || frame_drained;
        end
    end

    // Batch statistics and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_cfg_r   <= {COUNT_WIDTH{1'b0}};
            runs_r        <= {COUNT_WIDTH{1'b0}};
            fooled_r      <= {COUNT_WIDTH{1'b0}};
            sum_r         <= 32'd0;
            batch_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            if (accept_start_s) begin
                count_cfg_r <= cfg_run_count;
                runs_r      <= {COUNT_WIDTH{1'b0}};
                fooled_r    <= {COUNT_WIDTH{1'b0}};
                sum_r       <= 32'd0;
            end else if (take_done_s) begin
                runs_r   <= runs_r + COUNT_WIDTH'(1);
                fooled_r <= disc_fake_is_real ? (fooled_r + COUNT_WIDTH'(1)) : fooled_r;
                sum_r    <= sum_r + sext_score(disc_fake_score);
            end

            if ((state_nxt_s == ST_FINISH) && (state_r != ST_FINISH)) begin
                batch_done_r <= 1'b1;
            end else if (accept_start_s) begin
                batch_done_r <= 1'b0;
            end

            if (accept_start_s) begin
                timeout_err_r <= 1'b0;
            end else if (timeout_hit_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    assign gan_start      = gan_start_r;
    assign busy           = busy_r;
    assign batch_done     = batch_done_r;
    assign timeout_err    = timeout_err_r;
    assign runs_completed = runs_r;
    assign fooled_count   = fooled_r;
    assign fake_score_sum = sum_r;
    assign state_dbg      = state_r;

endmodule
